// File: rtl/demux2x32_reg.sv
// Registered 1-to-2 word demultiplexer with valid/ready handshakes.
// Destination comes from in_sel or from an alternating sequencer (auto_mode).
module demux2x32_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] y0_data,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1_data,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic             next_sel,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [WIDTH-1:0] y0_data_q, y0_data_d;
    logic [WIDTH-1:0] y1_data_q, y1_data_d;
    logic             y0_valid_q, y0_valid_d;
    logic             y1_valid_q, y1_valid_d;
    logic             next_sel_q, next_sel_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic dest;
    logic free0, free1;
    logic in_xfer;

    // A channel is free if empty or draining this cycle.
    assign dest     = auto_mode ? next_sel_q : in_sel;
    assign free0    = ~y0_valid_q | y0_ready;
    assign free1    = ~y1_valid_q | y1_ready;
    assign in_ready = dest ? free1 : free0;
    assign in_xfer  = in_valid & in_ready;

    always_comb begin
        y0_data_d  = y0_data_q;
        y1_data_d  = y1_data_q;
        y0_valid_d = y0_valid_q;
        y1_valid_d = y1_valid_q;
        next_sel_d = next_sel_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        if (y0_valid_q && y0_ready) y0_valid_d = 1'b0;
        if (y1_valid_q && y1_ready) y1_valid_d = 1'b0;

        // An input transfer overrides a same-cycle drain on its channel.
        if (in_xfer) begin
            if (dest) begin
                y1_data_d  = in_data;
                y1_valid_d = 1'b1;
                cnt1_d     = cnt1_q + CNT_W'(1);
            end else begin
                y0_data_d  = in_data;
                y0_valid_d = 1'b1;
                cnt0_d     = cnt0_q + CNT_W'(1);
            end
            if (auto_mode) next_sel_d = ~next_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y0_data_q  <= '0;
            y1_data_q  <= '0;
            y0_valid_q <= 1'b0;
            y1_valid_q <= 1'b0;
            next_sel_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            y0_data_q  <= y0_data_d;
            y1_data_q  <= y1_data_d;
            y0_valid_q <= y0_valid_d;
            y1_valid_q <= y1_valid_d;
            next_sel_q <= next_sel_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign y0_data  = y0_data_q;
    assign y1_data  = y1_data_q;
    assign y0_valid = y0_valid_q;
    assign y1_valid = y1_valid_q;
    assign next_sel = next_sel_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux2x32_reg.sv
// Bench for demux2x32_reg: directed scenarios plus random traffic, checked against
// a per-channel holding-slot model and per-channel word scoreboards.
module tb_demux2x32_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic        auto_mode;
    logic [31:0] y0_data;
    logic        y0_valid;
    logic        y0_ready;
    logic [31:0] y1_data;
    logic        y1_valid;
    logic        y1_ready;
    logic        next_sel;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    demux2x32_reg #(.WIDTH(32), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .auto_mode(auto_mode),
        .y0_data  (y0_data),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1_data  (y1_data),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .next_sel (next_sel),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each channel is a one-word slot; the sequencer is a plain bit.
    bit          m_valid[2];
    logic [31:0] m_data[2];
    bit          m_ptr;
    int          m_cnt[2];
    logic [31:0] sbq0[$];
    logic [31:0] sbq1[$];
    int          drained0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid[0] = 0; m_valid[1] = 0;
        m_data[0]  = '0; m_data[1] = '0;
        m_ptr      = 0;
        m_cnt[0]   = 0; m_cnt[1] = 0;
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic check_state();
        check_eq("y0_valid", y0_valid, m_valid[0]);
        check_eq("y1_valid", y1_valid, m_valid[1]);
        check_eq("y0_data", y0_data, m_data[0]);
        check_eq("y1_data", y1_data, m_data[1]);
        check_eq("next_sel", next_sel, m_ptr);
        check_eq("cnt0", cnt0, m_cnt[0]);
        check_eq("cnt1", cnt1, m_cnt[1]);
    endtask

    // One clock: inputs already driven; checks ready and drains, updates model.
    task automatic step();
        bit          dest, exp_ready, xin, rdy0, rdy1, am, r;
        logic [31:0] d, w;
        #1;
        r    = rst;
        am   = auto_mode;
        rdy0 = y0_ready;
        rdy1 = y1_ready;
        d    = in_data;
        dest = am ? m_ptr : in_sel;
        exp_ready = dest ? (!m_valid[1] || rdy1) : (!m_valid[0] || rdy0);
        xin  = in_valid && exp_ready && !r;
        if (!r) begin
            check_eq("in_ready", in_ready, exp_ready);
            if (m_valid[0] && rdy0) begin
                if (sbq0.size() == 0) check_eq("sb0_empty", 1, 0);
                else begin
                    w = sbq0.pop_front();
                    check_eq("sb0_word", y0_data, w);
                    drained0++;
                end
            end
            if (m_valid[1] && rdy1) begin
                if (sbq1.size() == 0) check_eq("sb1_empty", 1, 0);
                else begin
                    w = sbq1.pop_front();
                    check_eq("sb1_word", y1_data, w);
                end
            end
        end
        @(posedge clk);
        if (r) model_reset();
        else begin
            if (m_valid[0] && rdy0) m_valid[0] = 0;
            if (m_valid[1] && rdy1) m_valid[1] = 0;
            if (xin) begin
                m_valid[dest] = 1;
                m_data[dest]  = d;
                m_cnt[dest]   = (m_cnt[dest] + 1) % 256;
                if (dest) sbq1.push_back(d);
                else sbq0.push_back(d);
                if (am) m_ptr = !m_ptr;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0;
        step();
        rst = 0;
    endtask

    initial begin
        model_reset();
        drained0  = 0;
        rst       = 1;
        in_data   = '0;
        in_valid  = 0;
        in_sel    = 0;
        auto_mode = 0;
        y0_ready  = 0;
        y1_ready  = 0;
        @(negedge clk);
        step();
        rst = 0;

        // Reset with both channels loaded and a word presented.
        in_valid = 1; in_sel = 0; in_data = 32'h11; step();
        in_sel = 1; in_data = 32'h22; step();
        rst = 1; in_data = 32'h33; step();
        rst = 0; in_valid = 0;
        check_eq("rst_y0_valid", y0_valid, 0);
        check_eq("rst_y1_valid", y1_valid, 0);
        check_eq("rst_y0_data", y0_data, 0);
        check_eq("rst_cnt0", cnt0, 0);
        step();
        check_eq("rst_word_lost", y0_valid | y1_valid, 0);

        // Auto interleave 1,2,3,4.
        auto_mode = 1; y0_ready = 1; y1_ready = 1; in_valid = 1;
        in_data = 1; step(); check_eq("il_y0_1", y0_data, 1);
        in_data = 2; step(); check_eq("il_y1_2", y1_data, 2);
        in_data = 3; step(); check_eq("il_y0_3", y0_data, 3);
        in_data = 4; step(); check_eq("il_y1_4", y1_data, 4);
        check_eq("il_cnt0", cnt0, 2);
        check_eq("il_cnt1", cnt1, 2);
        check_eq("il_next_sel", next_sel, 0);
        in_valid = 0; step();

        // Backpressure on y0.
        y0_ready = 0; in_valid = 1;
        in_data = 32'hA; step();
        in_data = 32'hB; step();
        check_eq("bp_y1_B", y1_data, 32'hB);
        in_data = 32'hC; #1;
        check_eq("bp_c_blocked", in_ready, 0);
        step();
        check_eq("bp_y0_hold", y0_data, 32'hA);
        y0_ready = 1; #1;
        check_eq("bp_c_accept", in_ready, 1);
        step();
        check_eq("bp_y0_C", y0_data, 32'hC);
        check_eq("bp_no_bubble", y0_valid, 1);
        in_valid = 0; step();

        // Explicit select to y1.
        do_reset();
        auto_mode = 0; in_sel = 1; y1_ready = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h100 + i;
            step();
            check_eq("ex_y0_idle", y0_valid, 0);
        end
        check_eq("ex_cnt1", cnt1, 5);
        check_eq("ex_cnt0", cnt0, 0);
        check_eq("ex_next_sel", next_sel, 0);
        in_valid = 0; step();

        // Counter wrap on channel 0.
        do_reset();
        drained0 = 0;
        in_sel = 0; y0_ready = 1; in_valid = 1;
        for (int i = 0; i < 256; i++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 0;
        check_eq("wrap_cnt0", cnt0, 0);
        step();
        check_eq("wrap_drained", drained0, 256);
        check_eq("wrap_sb_empty", sbq0.size(), 0);

        // Drain and fill on the same channel.
        y0_ready = 0; in_valid = 1; in_sel = 0; in_data = 32'hDEAD; step();
        y0_ready = 1; in_data = 32'hBEEF; #1;
        check_eq("df_in_ready", in_ready, 1);
        step();
        check_eq("df_y0_valid", y0_valid, 1);
        check_eq("df_y0_data", y0_data, 32'hBEEF);
        in_valid = 0; step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = $urandom;
            in_sel    = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) auto_mode = !auto_mode;
            y0_ready  = $urandom_range(0, 2) != 0;
            y1_ready  = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux2x32_reg.md
# demux2x32_reg

Registered 1-to-2, 32-bit demultiplexer with valid/ready handshakes. It is the receiving end of a shared word bus driven by a 2:1 word multiplexer. Each accepted input word is steered into one of two single-entry output holding registers. The destination comes either from an explicit select or from an internal alternating sequencer that undoes a strictly interleaved stream. Per-channel word counters support debug and bench checking.

## Interface
- WIDTH, 32, data word width
- CNT_W, 8, width of per-channel word counters
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  shared input word
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  block can accept in_data this cycle
- in_sel  in  1  explicit destination (0 → y0, 1 → y1); used only when auto_mode=0
- auto_mode  in  1  1: destination from internal sequencer; 0: from in_sel
- y0_data  out  WIDTH  channel 0 held word
- y0_valid  out  1  channel 0 word present
- y0_ready  in  1  channel 0 consumer accepts
- y1_data  out  WIDTH  channel 1 held word
- y1_valid  out  1  channel 1 word present
- y1_ready  in  1  channel 1 consumer accepts
- next_sel  out  1  sequencer pointer (channel the next auto-mode word goes to)
- cnt0  out  CNT_W  words accepted into channel 0
- cnt1  out  CNT_W  words accepted into channel 1

## Operation
- Destination: dest = auto_mode ? next_sel : in_sel. It is evaluated combinationally every cycle.
- Channel k is free when yk_valid=0, or when yk_valid=1 and yk_ready=1 (a drain in the same cycle).
- in_ready = 1 when channel dest is free. It depends combinationally on auto_mode, in_sel, next_sel, yk_valid and yk_ready. It does not depend on in_valid.
- Input transfer occurs when in_valid and in_ready are both 1. On that clock edge:
  - ydest_data <= in_data
  - ydest_valid <= 1
  - cnt_dest increments
- Output transfer occurs when yk_valid and yk_ready are both 1. On that edge, yk_valid clears unless a new input transfer targets the same channel, in which case it stays 1 and data is replaced.
- The non-destination channel is unaffected by input. It can drain independently in the same cycle.
- Sequencer:
  - next_sel toggles on every input transfer made while auto_mode=1.
  - It holds when auto_mode=0 and when there is no transfer.
  - A stall on channel next_sel blocks the input; the sequencer never skips ahead to the other channel.
- Counters wrap modulo 2^CNT_W (255 → 0 for CNT_W=8). They count input transfers, not output transfers.
- The block never drops or duplicates a word. The upstream is responsible for holding in_data/in_sel stable while in_valid=1 and in_ready=0.

## Timing
- Reset values on the cycle after rst is sampled high:
  - y0_data = y1_data = 0
  - y0_valid = y1_valid = 0
  - next_sel = 0
  - cnt0 = cnt1 = 0
- in_ready is combinational; it may be 1 during reset.
- rst has priority over all transfers. Words held in the registers or presented during reset are discarded and not counted.
- Latency: a word accepted at edge N is on ydest_data with ydest_valid=1 from edge N until it is drained.
- Throughput: one word per cycle total. Each channel sustains one word per cycle with continuous yk_ready=1.
- Output stability: while yk_valid=1 and yk_ready=0, yk_data and yk_valid must not change.
- Mode change: auto_mode is sampled per cycle. Switching to 1 resumes from the retained next_sel value; switching to 0 freezes next_sel.
- Counter wrap coinciding with a transfer: the counter goes 255 → 0 with no side effect.

## Test plan
- Reset: preload both channels, then assert rst for 1 cycle with in_valid=1. Required: both valid=0, data=0, cnt=0, next_sel=0, and the presented word is lost.
- Auto interleave: auto_mode=1, both ready=1, feed 1,2,3,4 on consecutive cycles. Required:
  - y0 shows 1 then 3; y1 shows 2 then 4, each one cycle after acceptance.
  - cnt0 = cnt1 = 2; next_sel = 0.
- Backpressure: auto_mode=1, y0_ready=0, feed 0xA then 0xB then 0xC. Required:
  - 0xA held on y0; 0xB goes to y1; in_ready=0 for 0xC.
  - When y0_ready=1, 0xC is accepted in the same cycle 0xA drains, and y0_data becomes 0xC on the next edge with no bubble.
- Explicit select: auto_mode=0, in_sel=1, send 5 words with y1_ready=1. Required: all 5 go to y1, cnt1=5, cnt0=0, next_sel unchanged; y0_valid stays 0.
- Counter wrap: 256 words to channel 0. Required: cnt0 = 0 afterward, and no word is lost (a scoreboard matches all 256).
- Simultaneous drain and fill on the same channel: y0 full, y0_ready=1, input to y0. Required: in_ready=1, y0_valid stays 1, and data updates to the new word.
